// File: rtl/hazard_pkg.sv
// Shared constants, MDU state encoding and the per-source hazard compare.
package hazard_pkg;

    // Tuse code meaning "this source operand is not read".
    localparam logic [1:0] TUSE_NONE = 2'd3;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        StIdle = 1'b0,
        StBusy = 1'b1
    } mdState_e;

    // One source operand stalls when an in-flight producer targets it and its
    // result arrives later than ID needs it. Register 0 is hard-wired and never stalls.
    function automatic logic srcStall(
        input logic [4:0] src,
        input logic [1:0] tUse,
        input logic       wenEX,
        input logic [4:0] dstEX,
        input logic [2:0] tNewEX,
        input logic       wenMEM,
        input logic [4:0] dstMEM,
        input logic [2:0] tNewMEM
    );
        logic hitEX;
        logic hitMEM;
        logic lateEX;
        logic lateMEM;
        hitEX   = wenEX & (dstEX == src);
        hitMEM  = wenMEM & (dstMEM == src);
        lateEX  = tNewEX > {1'b0, tUse};
        lateMEM = tNewMEM > {1'b0, tUse};
        return (src != 5'd0) & (tUse != TUSE_NONE) &
               ((hitEX & lateEX) | (hitMEM & lateMEM));
    endfunction

endpackage

// File: rtl/md_busy_timer.sv
// Multiply/divide occupancy tracker: IDLE/BUSY FSM with a down-counter.
// mdBusy is high for exactly N cycles after the start edge; mdDone marks the last one.
module md_busy_timer
    import hazard_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int unsigned CNT_W       = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic mdStart,
    input  logic mdIsDiv,
    output logic mdBusy,
    output logic mdDone
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    mdState_e         stateQ, stateD;
    logic [CNT_W-1:0] timerQ, timerD;

    // State and timer registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stateQ <= StIdle;
            timerQ <= '0;
        end else begin
            stateQ <= stateD;
            timerQ <= timerD;
        end
    end

    // Next-state, timer load/decrement and done pulse.
    always_comb begin
        stateD = stateQ;
        timerD = timerQ;
        mdDone = 1'b0;
        unique case (stateQ)
            StIdle: begin
                if (mdStart) begin
                    stateD = StBusy;
                    timerD = mdIsDiv ? DIV_LOAD : MULT_LOAD;
                end
            end
            StBusy: begin
                // A start seen while busy (including the done cycle) is dropped.
                timerD = timerQ - CNT_ONE;
                if (timerQ == CNT_ONE) begin
                    mdDone = 1'b1;
                    stateD = StIdle;
                end
            end
            default: stateD = StIdle;
        endcase
    end

    assign mdBusy = (stateQ == StBusy);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall sequencer: Tuse/Tnew data-hazard compare, MDU occupancy
// hazard, stall fan-out to PC / IF/ID / ID/EX, and a saturating stall counter.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int unsigned CNT_W       = 4,
    parameter int unsigned PERF_W      = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [4:0]        rsInID,
    input  logic [4:0]        rtInID,
    input  logic [1:0]        tUseRsInID,
    input  logic [1:0]        tUseRtInID,
    input  logic              mdAccessInID,
    input  logic              regWriteEnabledInEX,
    input  logic [4:0]        regFinalDstInEX,
    input  logic [2:0]        tNewInEX,
    input  logic              regWriteEnabledInMEM,
    input  logic [4:0]        regFinalDstInMEM,
    input  logic [2:0]        tNewInMEM,
    input  logic              mdStartInEX,
    input  logic              mdIsDivInEX,
    output logic              stallOf_IF_ID,
    output logic              resetOf_ID_EX,
    output logic              pcWriteEnabled,
    output logic              mdBusy,
    output logic              mdDone,
    output logic [PERF_W-1:0] stallCycles
);

    localparam logic [PERF_W-1:0] PERF_ONE = PERF_W'(1);

    logic stallRs;
    logic stallRt;
    logic stallMd;
    logic stall;
    logic [PERF_W-1:0] stallCyclesQ;

    md_busy_timer #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (CNT_W)
    ) uMdTimer (
        .clk    (clk),
        .reset_n(reset_n),
        .mdStart(mdStartInEX),
        .mdIsDiv(mdIsDivInEX),
        .mdBusy (mdBusy),
        .mdDone (mdDone)
    );

    // Same-cycle hazard detection; forced inactive while reset is asserted.
    always_comb begin
        stallRs = srcStall(rsInID, tUseRsInID, regWriteEnabledInEX, regFinalDstInEX, tNewInEX,
                           regWriteEnabledInMEM, regFinalDstInMEM, tNewInMEM);
        stallRt = srcStall(rtInID, tUseRtInID, regWriteEnabledInEX, regFinalDstInEX, tNewInEX,
                           regWriteEnabledInMEM, regFinalDstInMEM, tNewInMEM);
        stallMd = mdAccessInID & (mdBusy | mdStartInEX);
        stall   = reset_n & (stallRs | stallRt | stallMd);
    end

    assign stallOf_IF_ID  = stall;
    assign resetOf_ID_EX  = stall;
    assign pcWriteEnabled = ~stall;

    // Stall-cycle counter, saturating at all-ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stallCyclesQ <= '0;
        end else if (stall && (stallCyclesQ != '1)) begin
            stallCyclesQ <= stallCyclesQ + PERF_ONE;
        end
    end

    assign stallCycles = stallCyclesQ;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (PERF_W=4 build).
module tb_pipeline_hazard_ctrl;

    logic       clk;
    logic       reset_n;
    logic [4:0] rsInID, rtInID;
    logic [1:0] tUseRsInID, tUseRtInID;
    logic       mdAccessInID;
    logic       regWriteEnabledInEX;
    logic [4:0] regFinalDstInEX;
    logic [2:0] tNewInEX;
    logic       regWriteEnabledInMEM;
    logic [4:0] regFinalDstInMEM;
    logic [2:0] tNewInMEM;
    logic       mdStartInEX, mdIsDivInEX;
    logic       stallOf_IF_ID, resetOf_ID_EX, pcWriteEnabled, mdBusy, mdDone;
    logic [3:0] stallCycles;

    int nAsserts = 0;
    int nFail    = 0;

    pipeline_hazard_ctrl #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10),
        .CNT_W      (4),
        .PERF_W     (4)
    ) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .rsInID              (rsInID),
        .rtInID              (rtInID),
        .tUseRsInID          (tUseRsInID),
        .tUseRtInID          (tUseRtInID),
        .mdAccessInID        (mdAccessInID),
        .regWriteEnabledInEX (regWriteEnabledInEX),
        .regFinalDstInEX     (regFinalDstInEX),
        .tNewInEX            (tNewInEX),
        .regWriteEnabledInMEM(regWriteEnabledInMEM),
        .regFinalDstInMEM    (regFinalDstInMEM),
        .tNewInMEM           (tNewInMEM),
        .mdStartInEX         (mdStartInEX),
        .mdIsDivInEX         (mdIsDivInEX),
        .stallOf_IF_ID       (stallOf_IF_ID),
        .resetOf_ID_EX       (resetOf_ID_EX),
        .pcWriteEnabled      (pcWriteEnabled),
        .mdBusy              (mdBusy),
        .mdDone              (mdDone),
        .stallCycles         (stallCycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed running expected finished");
        $fatal(1, "timeout");
    end

    // A start while the MDU is busy must never be presented by the pipeline.
    always @(posedge clk) begin
        if (reset_n && mdStartInEX && mdBusy) begin
            nFail++;
            $error("FAIL mdStartWhileBusy: observed start=1 busy=1 expected no start while busy");
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkStall(input string tag, input logic exp);
        chk({tag, ".stall"}, {31'd0, stallOf_IF_ID}, {31'd0, exp});
        chk({tag, ".bubble"}, {31'd0, resetOf_ID_EX}, {31'd0, exp});
        chk({tag, ".pcWe"}, {31'd0, pcWriteEnabled}, {31'd0, ~exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        rsInID = 5'd0; rtInID = 5'd0;
        tUseRsInID = 2'd3; tUseRtInID = 2'd3;
        mdAccessInID = 1'b0;
        regWriteEnabledInEX = 1'b0; regFinalDstInEX = 5'd0; tNewInEX = 3'd0;
        regWriteEnabledInMEM = 1'b0; regFinalDstInMEM = 5'd0; tNewInMEM = 3'd0;
        mdStartInEX = 1'b0; mdIsDivInEX = 1'b0;
    endtask

    task automatic pulseReset();
        @(negedge clk);
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        clearInputs();
        // Hazard-shaped inputs during reset must not stall.
        rsInID = 5'd1; tUseRsInID = 2'd1;
        regWriteEnabledInEX = 1'b1; regFinalDstInEX = 5'd1; tNewInEX = 3'd2;
        #1;
        chkStall("reset", 1'b0);
        chk("reset.mdBusy", {31'd0, mdBusy}, 32'd0);
        chk("reset.mdDone", {31'd0, mdDone}, 32'd0);
        chk("reset.stallCycles", {28'd0, stallCycles}, 32'd0);
        clearInputs();
        @(negedge clk);
        reset_n = 1'b1;
        #1;

        // 1. lw $1 in EX, ID add reads $1 at tUse=1.
        rsInID = 5'd1; tUseRsInID = 2'd1;
        regWriteEnabledInEX = 1'b1; regFinalDstInEX = 5'd1; tNewInEX = 3'd2;
        #1;
        chkStall("t1.exHit", 1'b1);
        tick();
        chk("t1.count1", {28'd0, stallCycles}, 32'd1);
        regWriteEnabledInEX = 1'b0; regFinalDstInEX = 5'd0; tNewInEX = 3'd0;
        regWriteEnabledInMEM = 1'b1; regFinalDstInMEM = 5'd1; tNewInMEM = 3'd1;
        #1;
        chkStall("t1.memReady", 1'b0);
        tick();
        chk("t1.countHeld", {28'd0, stallCycles}, 32'd1);

        // 2. Register $0 never stalls.
        clearInputs();
        rsInID = 5'd0; tUseRsInID = 2'd0; rtInID = 5'd0; tUseRtInID = 2'd0;
        regWriteEnabledInEX = 1'b1; regFinalDstInEX = 5'd0; tNewInEX = 3'd2;
        #1;
        chkStall("t2.reg0", 1'b0);

        // 3. mult start with mflo in ID: 1 start cycle + 5 busy cycles stalled.
        clearInputs();
        mdAccessInID = 1'b1;
        mdStartInEX = 1'b1; mdIsDivInEX = 1'b0;
        #1;
        chkStall("t3.startCycle", 1'b1);
        chk("t3.idleBusy", {31'd0, mdBusy}, 32'd0);
        tick();
        mdStartInEX = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            #1;
            chk($sformatf("t3.busy%0d", i), {31'd0, mdBusy}, 32'd1);
            chk($sformatf("t3.done%0d", i), {31'd0, mdDone}, (i == 5) ? 32'd1 : 32'd0);
            chkStall($sformatf("t3.cyc%0d", i), 1'b1);
            tick();
        end
        chk("t3.busyEnd", {31'd0, mdBusy}, 32'd0);
        chk("t3.doneEnd", {31'd0, mdDone}, 32'd0);
        chkStall("t3.released", 1'b0);
        chk("t3.count", {28'd0, stallCycles}, 32'd7);

        // 4. div start, async reset on busy cycle 4.
        clearInputs();
        mdStartInEX = 1'b1; mdIsDivInEX = 1'b1;
        tick();
        mdStartInEX = 1'b0; mdIsDivInEX = 1'b0;
        tick(); tick(); tick();
        chk("t4.busyCyc4", {31'd0, mdBusy}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t4.rstBusy", {31'd0, mdBusy}, 32'd0);
        chk("t4.rstCount", {28'd0, stallCycles}, 32'd0);
        chk("t4.rstDone", {31'd0, mdDone}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk($sformatf("t4.noDone%0d", i), {30'd0, mdBusy, mdDone}, 32'd0);
        end

        // 5. Saturation: 2^4 + 3 stalled cycles.
        clearInputs();
        rsInID = 5'd5; tUseRsInID = 2'd0;
        regWriteEnabledInEX = 1'b1; regFinalDstInEX = 5'd5; tNewInEX = 3'd1;
        repeat (14) tick();
        chk("t5.count14", {28'd0, stallCycles}, 32'd14);
        repeat (5) tick();
        chk("t5.saturated", {28'd0, stallCycles}, 32'hF);
        chkStall("t5.stillStall", 1'b1);

        // 6. rs hit in EX and rt hit in MEM together, both tUse=0.
        clearInputs();
        pulseReset();
        rsInID = 5'd3; tUseRsInID = 2'd0;
        regWriteEnabledInEX = 1'b1; regFinalDstInEX = 5'd3; tNewInEX = 3'd1;
        rtInID = 5'd4; tUseRtInID = 2'd0;
        regWriteEnabledInMEM = 1'b1; regFinalDstInMEM = 5'd4; tNewInMEM = 3'd1;
        #1;
        chkStall("t6.both", 1'b1);
        tick();
        chk("t6.count1", {28'd0, stallCycles}, 32'd1);
        tNewInEX = 3'd0;
        #1;
        chkStall("t6.rtOnly", 1'b1);
        tick();
        chk("t6.count2", {28'd0, stallCycles}, 32'd2);
        tUseRtInID = 2'd3;
        #1;
        chkStall("t6.rtUnused", 1'b0);
        tUseRtInID = 2'd0; tNewInMEM = 3'd0;
        #1;
        chkStall("t6.cleared", 1'b0);
        tick();
        chk("t6.countHeld", {28'd0, stallCycles}, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule
